memory_responder: RTL and testbench

//   Responder side of the controller's memory-request interface. Accepts one

---
 rtl/memory_responder_pkg.sv | 20 ++
 rtl/memory_responder_synchronizer.sv | 32 +++
 rtl/memory_responder.sv | 130 +++++++++++++
 tb/tb_memory_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder_pkg
// Brief    : Memory-map addresses and responder FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package memory_responder_pkg;

    localparam logic [15:0] IO_LEDS_ADDRESS     = 16'hFFF0;
    localparam logic [15:0] IO_SWITCHES_ADDRESS = 16'hFFF1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/memory_responder_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder_synchronizer
// Brief    : Two-flop synchronizer for asynchronous board inputs.
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder_synchronizer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Brief    : Single-outstanding memory request responder for block RAM and
//            memory-mapped LEDs/switches, with held valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int RAM_ADDRESS_WIDTH = 10,
    parameter int IO_WIDTH          = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         request_valid,
    output logic                         request_ready,
    input  logic                         request_write,
    input  logic [ADDRESS_WIDTH-1:0]     request_address,
    input  logic [DATA_WIDTH-1:0]        request_write_data,
    output logic                         response_valid,
    input  logic                         response_ready,
    output logic [DATA_WIDTH-1:0]        response_data,
    output logic                         response_error,
    output logic [RAM_ADDRESS_WIDTH-1:0] ram_address,
    output logic                         ram_write_enable,
    output logic [DATA_WIDTH-1:0]        ram_write_data,
    input  logic [DATA_WIDTH-1:0]        ram_read_data,
    input  logic [IO_WIDTH-1:0]          switches,
    output logic [IO_WIDTH-1:0]          leds
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_response_data;
    logic                     r_response_error;
    logic [IO_WIDTH-1:0]      r_leds;
    logic [IO_WIDTH-1:0]      w_switches_sync;

    logic w_is_ram;
    logic w_is_leds;
    logic w_is_switches;
    logic w_access_error;

    memory_responder_synchronizer #(
        .WIDTH (IO_WIDTH)
    ) u_switch_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (switches),
        .o_sync  (w_switches_sync)
    );

    assign w_is_ram       = (r_address >> RAM_ADDRESS_WIDTH) == '0;
    assign w_is_leds      = r_address == ADDRESS_WIDTH'(IO_LEDS_ADDRESS);
    assign w_is_switches  = r_address == ADDRESS_WIDTH'(IO_SWITCHES_ADDRESS);
    assign w_access_error = !(w_is_ram || w_is_leds || w_is_switches)
                          || (w_is_switches && r_write);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (request_valid) w_next_state = ST_ACCESS;
            // Only RAM loads need the extra cycle for the synchronous read
            ST_ACCESS:  w_next_state = (w_is_ram && !r_write) ? ST_CAPTURE : ST_RESPOND;
            ST_CAPTURE: w_next_state = ST_RESPOND;
            ST_RESPOND: if (response_ready) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_address        <= '0;
            r_write          <= 1'b0;
            r_write_data     <= '0;
            r_response_data  <= '0;
            r_response_error <= 1'b0;
            r_leds           <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (request_valid) begin
                        r_address    <= request_address;
                        r_write      <= request_write;
                        r_write_data <= request_write_data;
                    end
                end
                ST_ACCESS: begin
                    r_response_error <= w_access_error;
                    r_response_data  <= '0;
                    if (r_write) begin
                        if (w_is_leds) r_leds <= r_write_data[IO_WIDTH-1:0];
                    end else if (w_is_leds) begin
                        r_response_data <= DATA_WIDTH'(r_leds);
                    end else if (w_is_switches) begin
                        r_response_data <= DATA_WIDTH'(w_switches_sync);
                    end
                end
                ST_CAPTURE: r_response_data <= ram_read_data;
                default: ;
            endcase
        end
    end

    // Reset gates the strobe so an abandoned store never reaches the RAM
    assign ram_write_enable = !reset && (r_state == ST_ACCESS) && r_write && w_is_ram;
    assign ram_address      = r_address[RAM_ADDRESS_WIDTH-1:0];
    assign ram_write_data   = r_write_data;
    assign request_ready    = (r_state == ST_IDLE);
    assign response_valid   = (r_state == ST_RESPOND);
    assign response_data    = r_response_data;
    assign response_error   = r_response_error;
    assign leds             = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_responder
// Brief    : Self-checking bench for memory_responder against a memory-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [15:0] request_address;
    logic [15:0] request_write_data;
    logic        response_valid;
    logic        response_ready;
    logic [15:0] response_data;
    logic        response_error;
    logic [9:0]  ram_address;
    logic        ram_write_enable;
    logic [15:0] ram_write_data;
    logic [15:0] ram_read_data;
    logic [9:0]  switches;
    logic [9:0]  leds;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ram_mem [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [9:0]  ref_leds;
    int          we_count = 0;

    always #5 clock = ~clock;

    memory_responder dut (
        .clock              (clock),
        .reset              (reset),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .request_write      (request_write),
        .request_address    (request_address),
        .request_write_data (request_write_data),
        .response_valid     (response_valid),
        .response_ready     (response_ready),
        .response_data      (response_data),
        .response_error     (response_error),
        .ram_address        (ram_address),
        .ram_write_enable   (ram_write_enable),
        .ram_write_data     (ram_write_data),
        .ram_read_data      (ram_read_data),
        .switches           (switches),
        .leds               (leds)
    );

    // External synchronous block RAM, one-cycle read latency
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_write_data;
        ram_read_data <= ram_mem[ram_address];
        if (ram_write_enable) we_count <= we_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_switches(input logic [9:0] v);
        @(negedge clock);
        switches = v;
        repeat (3) @(negedge clock);
    endtask

    // One full transaction, checked against the memory-map model
    task automatic transact(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            input int hold);
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        int          we0;
        int          k;
        logic [15:0] held_data;
        logic        held_err;

        exp_data = 16'h0;
        exp_err  = 1'b0;
        exp_lat  = 2;
        exp_we   = 0;
        if (a < 16'd1024) begin
            if (wr) begin
                exp_we = 1;
                ref_mem[a[9:0]] = d;
            end else begin
                exp_data = ref_mem[a[9:0]];
                exp_lat  = 3;
            end
        end else if (a == 16'hFFF0) begin
            if (wr) ref_leds = d[9:0];
            else    exp_data = {6'b0, ref_leds};
        end else if (a == 16'hFFF1) begin
            if (wr) exp_err = 1'b1;
            else    exp_data = {6'b0, switches};
        end else begin
            exp_err = 1'b1;
        end

        @(negedge clock);
        chk("request_ready_idle", {31'b0, request_ready}, 32'd1);
        request_valid      = 1'b1;
        request_write      = wr;
        request_address    = a;
        request_write_data = d;
        we0 = we_count;
        @(posedge clock);
        #1;
        request_valid      = 1'b0;
        request_write      = 1'($urandom);
        request_address    = 16'($urandom);
        request_write_data = 16'($urandom);

        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!response_valid && k < 12);
        chk("latency", k, exp_lat);
        chk("response_data", {16'b0, response_data}, {16'b0, exp_data});
        chk("response_error", {31'b0, response_error}, {31'b0, exp_err});
        held_data = response_data;
        held_err  = response_error;

        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("held_valid", {31'b0, response_valid}, 32'd1);
            chk("held_data", {16'b0, response_data}, {16'b0, held_data});
            chk("held_error", {31'b0, response_error}, {31'b0, held_err});
            chk("held_request_ready", {31'b0, request_ready}, 32'd0);
        end

        response_ready = 1'b1;
        @(negedge clock);
        response_ready = 1'b0;
        chk("valid_after_accept", {31'b0, response_valid}, 32'd0);
        chk("ready_after_accept", {31'b0, request_ready}, 32'd1);
        chk("ram_we_pulses", we_count - we0, exp_we);
        chk("leds", {22'b0, leds}, {22'b0, ref_leds});
    endtask

    initial begin
        logic [15:0] a;
        logic        wr;
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        ref_leds           = 10'h0;
        reset              = 1'b1;
        request_valid      = 1'b0;
        request_write      = 1'b0;
        request_address    = 16'h0;
        request_write_data = 16'h0;
        response_ready     = 1'b0;
        switches           = 10'h0;
        repeat (3) @(negedge clock);
        chk("rst_response_valid", {31'b0, response_valid}, 32'd0);
        chk("rst_response_data", {16'b0, response_data}, 32'd0);
        chk("rst_response_error", {31'b0, response_error}, 32'd0);
        chk("rst_leds", {22'b0, leds}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_write_enable}, 32'd0);
        chk("rst_request_ready", {31'b0, request_ready}, 32'd1);
        reset = 1'b0;

        // Directed scenarios
        transact(1'b1, 16'h0005, 16'hBEEF, 1);
        transact(1'b0, 16'h0005, 16'h0000, 0);
        transact(1'b1, 16'hFFF0, 16'h03A5, 0);
        transact(1'b0, 16'hFFF0, 16'h0000, 2);
        set_switches(10'h2C3);
        transact(1'b0, 16'hFFF1, 16'h0000, 0);
        transact(1'b1, 16'hFFF1, 16'h1234, 0);
        transact(1'b0, 16'h8000, 16'h0000, 5);
        transact(1'b1, 16'h0007, 16'h1111, 0);
        transact(1'b1, 16'h03FF, 16'hA5A5, 0);
        transact(1'b0, 16'h03FF, 16'h0000, 0);
        transact(1'b0, 16'h0400, 16'h0000, 0);

        // Reset while the store to 0x0007 is in ACCESS
        @(negedge clock);
        request_valid      = 1'b1;
        request_write      = 1'b1;
        request_address    = 16'h0007;
        request_write_data = 16'h7777;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        chk("rst_access_no_we", {31'b0, ram_write_enable}, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        ref_leds = 10'h0;
        chk("rst_access_valid", {31'b0, response_valid}, 32'd0);
        chk("rst_access_data", {16'b0, response_data}, 32'd0);
        chk("rst_access_error", {31'b0, response_error}, 32'd0);
        chk("rst_access_leds", {22'b0, leds}, 32'd0);
        chk("rst_access_ready", {31'b0, request_ready}, 32'd1);
        set_switches(10'h2C3);
        transact(1'b0, 16'h0007, 16'h0000, 0);

        // Randomized traffic over every decode region
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    a = 16'($urandom_range(0, 15));
                2:       a = 16'hFFF0;
                3:       a = 16'hFFF1;
                4:       a = 16'($urandom_range(1024, 16'hFFEF));
                default: a = 16'($urandom_range(1020, 1023));
            endcase
            if (a == 16'hFFF1 && !wr) set_switches(10'($urandom));
            transact(wr, a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
